// File: rtl/axi_r_responder.sv
// AXI read-channel responder: turns one AR burst at a time into memory reads
// and streams the results out on R through a 2-entry skid FIFO.
module axi_r_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 busy_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the sender holds payload stable while valid is high and ready is low.

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespSlv   = 2'b10;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q;
  logic [7:0]            len_q;
  logic [IdWidth-1:0]    id_q;
  logic                  err_q;
  logic [8:0]            issue_q;
  logic [7:0]            beat_q;
  logic                  inflight_q;
  logic [DataWidth-1:0]  fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic ar_fire, r_fire, issue;

  assign r_valid_o = (count_q != 2'd0);
  assign r_fire    = r_valid_o && r_ready_i;
  assign ar_fire   = ar_valid_i && ar_ready_o;

  // A beat leaving the FIFO this cycle frees its slot for the read issued now,
  // which is what allows one beat per cycle with only two entries.
  assign issue = (state_q == BURST) && (issue_q <= {1'b0, len_q}) &&
                 (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, r_fire}));

  assign mem_req_o  = issue && !err_q;
  assign mem_addr_o = addr_q + AddrWidth'({issue_q, 3'b000});

  assign r_data_o = fifo_q[rd_ptr_q];
  assign r_resp_o = (r_valid_o && err_q) ? RespSlv : RespOkay;
  assign r_last_o = r_valid_o && (beat_q == len_q);
  assign r_id_o   = id_q;
  assign busy_o   = (state_q == BURST);

  always_comb begin
    state_d    = state_q;
    ar_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        ar_ready_o = rst_ni;
        if (ar_valid_i && rst_ni) state_d = BURST;
      end
      BURST: begin
        if (r_fire && r_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      issue_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (ar_fire) begin
        addr_q  <= ar_addr_i;
        len_q   <= ar_len_i;
        id_q    <= ar_id_i;
        err_q   <= (ar_burst_i != BurstIncr) || (ar_size_i != 3'd3);
        issue_q <= '0;
        beat_q  <= '0;
      end else begin
        if (issue)  issue_q <= issue_q + 9'd1;
        if (r_fire) beat_q  <= beat_q + 8'd1;
      end
      // Error bursts still pass through the pipeline so beat timing is uniform.
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= err_q ? '0 : mem_rdata_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (r_fire) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, r_fire};
    end
  end

endmodule

// File: tb/tb_axi_r_responder.sv
// Directed and randomized bursts against a queue-based model of AR -> R.
module tb_axi_r_responder;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ar_valid_i = 1'b0;
  logic          ar_ready_o;
  logic [AW-1:0] ar_addr_i = '0;
  logic [7:0]    ar_len_i = '0;
  logic [2:0]    ar_size_i = '0;
  logic [1:0]    ar_burst_i = '0;
  logic [IW-1:0] ar_id_i = '0;
  logic          r_valid_o;
  logic          r_ready_i = 1'b0;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic [IW-1:0] r_id_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  axi_r_responder #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
    .r_last_o(r_last_o), .r_id_o(r_id_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  logic [AW-1:0] exp_addr_q[$];
  beat_t         exp_beat_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issued = 0;
  int accepted = 0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_stall = 1'b0;
  beat_t         prev_beat = '0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[31:0], ~a[63:32]} ^ 64'h0123_4567_89ab_cdef;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later.
  task automatic step(input logic av, input logic rdy, output logic ar_hs, output logic r_hs);
    beat_t cur;
    @(negedge clk_i);
    cyc++;
    mem_rdata_i = prev_req ? mem_fn(prev_addr) : {$urandom, $urandom};
    ar_valid_i  = av;
    r_ready_i   = rdy;
    #1;
    ar_hs = ar_valid_i && ar_ready_o;
    r_hs  = r_valid_o && r_ready_i;
    cur   = '{r_data_o, r_resp_o, r_last_o, r_id_o};
    if (prev_stall) begin
      chk("stall_valid", r_valid_o, 1'b1);
      chk("stall_payload", cur, prev_beat);
    end
    if (mem_req_o) begin
      issued++;
      if (exp_addr_q.size() == 0) chk("mem_req_unexpected", 1'b1, 1'b0);
      else chk("mem_addr", mem_addr_o, exp_addr_q.pop_front());
    end
    if (r_hs) begin
      accepted++;
      if (exp_beat_q.size() == 0) chk("beat_unexpected", 1'b1, 1'b0);
      else chk("beat", cur, exp_beat_q.pop_front());
    end
    chk("outstanding_le2", (issued - accepted) <= 2, 1'b1);
    prev_stall = r_valid_o && !r_ready_i;
    prev_beat  = cur;
    prev_req   = mem_req_o;
    prev_addr  = mem_addr_o;
  endtask

  function automatic logic rdy_pat(input int mode, input int t);
    case (mode)
      0: return 1'b1;
      1: return (t % 3) == 0;
      default: return 1'(($urandom & 3) != 0);
    endcase
  endfunction

  // mode: 0 always ready, 1 ready pattern 1,0,0, 2 random; stop_after<0 runs to completion.
  task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [IW-1:0] id, input int mode,
                           input logic hold_ar, input int stop_after);
    logic ar_hs, r_hs, err;
    int t, nbeats, hs_cyc, last_cyc;
    ar_addr_i = addr; ar_len_i = len; ar_size_i = size; ar_burst_i = burst; ar_id_i = id;
    err = (burst != 2'b01) || (size != 3'd3);
    issued = 0; accepted = 0; ar_hs = 1'b0; t = 0;
    while (!ar_hs && t < 20) begin
      step(1'b1, 1'b1, ar_hs, r_hs);
      t++;
    end
    chk("ar_handshake", ar_hs, 1'b1);
    hs_cyc = cyc;
    for (int k = 0; k <= int'(len); k++) begin
      logic [AW-1:0] a;
      a = addr + AW'(8 * k);
      if (!err) exp_addr_q.push_back(a);
      exp_beat_q.push_back('{err ? '0 : mem_fn(a), err ? 2'b10 : 2'b00, k == int'(len), id});
    end
    nbeats = 0; t = 0; last_cyc = 0;
    while (nbeats < int'(len) + 1 && nbeats != stop_after && t < 2000) begin
      step(hold_ar, rdy_pat(mode, t), ar_hs, r_hs);
      if (t == 0) begin
        chk("busy_in_burst", busy_o, 1'b1);
        chk("ar_ready_in_burst", ar_ready_o, 1'b0);
      end
      if (hold_ar) chk("ar_ignored_busy", ar_hs, 1'b0);
      if (r_hs) begin
        if (mode == 0) begin
          if (nbeats == 0) chk("first_beat_latency", cyc - hs_cyc, 3);
          else chk("back_to_back", cyc - last_cyc, 1);
        end
        last_cyc = cyc;
        nbeats++;
      end
      t++;
    end
    if (t >= 2000) chk("burst_timeout", 1'b0, 1'b1);
    if (stop_after < 0) begin
      step(1'b0, 1'b1, ar_hs, r_hs);
      chk("ar_ready_after_last", ar_ready_o, 1'b1);
      chk("idle_after_last", busy_o, 1'b0);
      chk("model_drained", exp_beat_q.size() + exp_addr_q.size(), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ar_ready"}, ar_ready_o, 1'b0);
    chk({tag, "_r_valid"}, r_valid_o, 1'b0);
    chk({tag, "_r_last"}, r_last_o, 1'b0);
    chk({tag, "_mem_req"}, mem_req_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_payload"}, {r_data_o, r_resp_o, r_id_o}, '0);
    chk({tag, "_mem_addr"}, mem_addr_o, '0);
  endtask

  task automatic release_reset();
    logic ar_hs, r_hs;
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_addr_q.delete(); exp_beat_q.delete();
    prev_req = 1'b0; prev_stall = 1'b0;
    step(1'b0, 1'b0, ar_hs, r_hs);
    chk("ar_ready_after_release", ar_ready_o, 1'b1);
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk_i);
    release_reset();

    run_burst(64'h1000, 8'd3, 3'd3, 2'b01, 4'd5, 0, 1'b0, -1);
    run_burst(64'h2000, 8'd0, 3'd3, 2'b01, 4'd9, 0, 1'b0, -1);
    run_burst(64'h3000, 8'd7, 3'd3, 2'b01, 4'd3, 1, 1'b1, -1);
    run_burst(64'h4000, 8'd2, 3'd3, 2'b00, 4'd7, 0, 1'b0, -1);
    run_burst(64'h5000, 8'd1, 3'd2, 2'b01, 4'd2, 1, 1'b0, -1);
    run_burst(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01, 4'd1, 0, 1'b0, -1);
    run_burst(64'h8000, 8'd255, 3'd3, 2'b01, 4'd15, 0, 1'b0, -1);

    run_burst(64'h6000, 8'd5, 3'd3, 2'b01, 4'd4, 0, 1'b0, 2);
    @(negedge clk_i);
    rst_ni = 1'b0;
    r_ready_i = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk_i);
    release_reset();
    run_burst(64'h7000, 8'd4, 3'd3, 2'b01, 4'd6, 2, 1'b0, -1);

    for (int i = 0; i < 12; i++) begin
      logic [AW-1:0] a;
      logic [1:0] b;
      logic [2:0] s;
      a = {$urandom, $urandom} & ~64'h7;
      b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b01;
      s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      run_burst(a, 8'($urandom_range(0, 12)), s, b, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
